// File: rtl/spec_packer.sv
// Packs 16-bit requantized samples four at a time into 64-bit words, framed
// by spectrum sync, and queues them in a small output FIFO with AXI-Stream-like handshake.
module spec_packer #(
   parameter int NCHAN      = 2048,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        sync_in,
   input  logic [15:0] data_in,
   output logic [63:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic [31:0] spec_count,
   output logic        drop,
   output logic        resync,
   input  logic        clr
);

   localparam int CW = $clog2(NCHAN);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {
      WAIT_SYNC,
      PACKING
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CW-1:0]      r_chan;
   logic [2:0][15:0]   r_lane;
   logic [63:0]        r_word;
   logic               r_word_last;
   logic               r_push;
   logic [64:0]        r_mem [FIFO_DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_count;
   logic [31:0]        r_spec_count;
   logic               r_drop;
   logic               r_resync;

   logic               w_restart;
   logic               w_sample_ok;
   logic               w_resync_evt;
   logic [CW-1:0]      w_eff_chan;
   logic               w_lane3;
   logic               w_last_chan;
   logic               w_full;
   logic               w_pop;
   logic               w_push_ok;
   logic               w_drop_evt;

   // A sync sample always lands on channel 0, whatever the counter says.
   assign w_restart    = ce && sync_in;
   assign w_sample_ok  = ce && (r_state == PACKING || sync_in);
   assign w_resync_evt = w_restart && (r_state == PACKING) && (r_chan != '0);
   assign w_eff_chan   = w_restart ? '0 : r_chan;
   assign w_lane3      = w_sample_ok && (w_eff_chan[1:0] == 2'd3);
   assign w_last_chan  = (w_eff_chan == CW'(NCHAN - 1));

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == WAIT_SYNC && w_restart)
         w_state_nxt = PACKING;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= WAIT_SYNC;
      else      r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_chan      <= '0;
         r_lane      <= '0;
         r_word      <= '0;
         r_word_last <= 1'b0;
         r_push      <= 1'b0;
      end else begin
         r_push <= w_lane3;
         if (w_sample_ok) begin
            r_chan <= w_last_chan ? '0 : w_eff_chan + CW'(1);
            case (w_eff_chan[1:0])
               2'd0:    r_lane[0] <= data_in;
               2'd1:    r_lane[1] <= data_in;
               2'd2:    r_lane[2] <= data_in;
               default: begin
                  r_word      <= {data_in, r_lane[2], r_lane[1], r_lane[0]};
                  r_word_last <= w_last_chan;
               end
            endcase
         end
      end
   end

   // A push into a full FIFO still succeeds when the head leaves in the same cycle.
   assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_pop      = (r_count != '0) && m_tready;
   assign w_push_ok  = r_push && (!w_full || w_pop);
   assign w_drop_evt = r_push && w_full && !w_pop;

   // NOTE: FIFO storage is not reset; the outputs are gated by m_tvalid instead.
   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= {r_word_last, r_word};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_spec_count <= '0;
         r_drop       <= 1'b0;
         r_resync     <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_push_ok && r_word_last)
            r_spec_count <= r_spec_count + 32'd1;
         // Setting events win over a concurrent clear.
         if (w_drop_evt)   r_drop   <= 1'b1;
         else if (clr)     r_drop   <= 1'b0;
         if (w_resync_evt) r_resync <= 1'b1;
         else if (clr)     r_resync <= 1'b0;
      end
   end

   assign m_tvalid   = (r_count != '0);
   assign m_tdata    = m_tvalid ? r_mem[r_rd_ptr][63:0] : '0;
   assign m_tlast    = m_tvalid && r_mem[r_rd_ptr][64];
   assign spec_count = r_spec_count;
   assign drop       = r_drop;
   assign resync     = r_resync;

endmodule

// File: tb/tb_spec_packer.sv
// Directed bench for spec_packer with NCHAN=8, FIFO_DEPTH=4; a posedge monitor
// records every transferred word as {tlast, tdata}.
module tb_spec_packer;

   localparam int NCHAN      = 8;
   localparam int FIFO_DEPTH = 4;

   logic        clk      = 1'b0;
   logic        rst      = 1'b0;
   logic        ce       = 1'b0;
   logic        sync_in  = 1'b0;
   logic [15:0] data_in  = '0;
   logic        m_tready = 1'b0;
   logic        clr      = 1'b0;
   logic [63:0] m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic [31:0] spec_count;
   logic        drop;
   logic        resync;

   int          checks = 0;
   int          errors = 0;
   logic [64:0] q[$];

   spec_packer #(.NCHAN(NCHAN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .sync_in    (sync_in),
      .data_in    (data_in),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast),
      .spec_count (spec_count),
      .drop       (drop),
      .resync     (resync),
      .clr        (clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (rst && m_tvalid && m_tready)
         q.push_back({m_tlast, m_tdata});

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      check(tag, {64'd0, obs}, {64'd0, exp});
   endtask

   task automatic chk_word(input string tag, input int idx, input logic [64:0] exp);
      logic [64:0] obs;
      obs = (idx < q.size()) ? q[idx] : '1;
      check(tag, obs, exp);
   endtask

   task automatic drive(input logic c, input logic s, input logic [15:0] d);
      @(negedge clk);
      ce      = c;
      sync_in = s;
      data_in = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 16'h0000);
   endtask

   task automatic wait_words(input int n, input string tag);
      int k;
      k = 0;
      while (q.size() < n && k < 50) begin
         @(negedge clk);
         k++;
      end
      check(tag, 65'(q.size()), 65'(n));
   endtask

   task automatic ramp_spectrum(input int gap);
      for (int c = 0; c < NCHAN; c++) begin
         drive(1'b1, c == 0, 16'(c));
         idle(gap);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1;
      chk_bit("rst_tvalid", m_tvalid, 1'b0);
      chk_bit("rst_tlast", m_tlast, 1'b0);
      check("rst_tdata", {1'b0, m_tdata}, 65'd0);
      check("rst_spec_count", {33'd0, spec_count}, 65'd0);
      chk_bit("rst_drop", drop, 1'b0);
      chk_bit("rst_resync", resync, 1'b0);
      #12 rst = 1'b1;
      m_tready = 1'b1;

      // Samples before any sync are ignored
      repeat (3) drive(1'b1, 1'b0, 16'hAAAA);
      idle(4);
      check("waitsync_discard", 65'(q.size()), 65'd0);

      // Basic ramp, with latency check on the final word
      ramp_spectrum(0);
      idle(1);
      @(negedge clk);
      chk_bit("ramp_latency_tvalid", m_tvalid, 1'b1);
      check("ramp_latency_word", {m_tlast, m_tdata}, {1'b1, 64'h0007_0006_0005_0004});
      wait_words(2, "ramp_count");
      chk_word("ramp_w0", 0, {1'b0, 64'h0003_0002_0001_0000});
      chk_word("ramp_w1", 1, {1'b1, 64'h0007_0006_0005_0004});
      check("ramp_spec_count", {33'd0, spec_count}, 65'd1);
      q.delete();

      // Same spectrum with ce at 1-in-3 duty; sync at expected channel 0
      ramp_spectrum(2);
      idle(3);
      wait_words(2, "duty_count");
      chk_word("duty_w0", 0, {1'b0, 64'h0003_0002_0001_0000});
      chk_word("duty_w1", 1, {1'b1, 64'h0007_0006_0005_0004});
      check("duty_spec_count", {33'd0, spec_count}, 65'd2);
      chk_bit("duty_no_resync", resync, 1'b0);
      q.delete();

      // Resync at channel 5
      drive(1'b1, 1'b1, 16'h0100);
      for (int c = 1; c <= 4; c++) drive(1'b1, 1'b0, 16'h0100 + 16'(c));
      drive(1'b1, 1'b1, 16'h0200);
      for (int c = 1; c <= 7; c++) drive(1'b1, 1'b0, 16'h0200 + 16'(c));
      idle(3);
      wait_words(3, "resync_count");
      chk_word("resync_w0", 0, {1'b0, 64'h0103_0102_0101_0100});
      chk_word("resync_w1", 1, {1'b0, 64'h0203_0202_0201_0200});
      chk_word("resync_w2", 2, {1'b1, 64'h0207_0206_0205_0204});
      chk_bit("resync_flag", resync, 1'b1);
      check("resync_spec_count", {33'd0, spec_count}, 65'd3);
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      chk_bit("resync_clr", resync, 1'b0);
      q.delete();

      // Backpressure: three spectra into a 4-word FIFO
      m_tready = 1'b0;
      for (int s = 1; s <= 3; s++)
         for (int c = 0; c < NCHAN; c++)
            drive(1'b1, (s == 1) && (c == 0), 16'(s * 4096 + c));
      idle(3);
      check("bp_no_transfer", 65'(q.size()), 65'd0);
      chk_bit("bp_tvalid", m_tvalid, 1'b1);
      check("bp_head", {m_tlast, m_tdata}, {1'b0, 64'h1003_1002_1001_1000});
      chk_bit("bp_drop", drop, 1'b1);
      check("bp_spec_count", {33'd0, spec_count}, 65'd5);

      // clr clears drop; clr concurrent with a new drop leaves it set
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      chk_bit("clr_drop", drop, 1'b0);
      for (int c = 0; c < 4; c++) drive(1'b1, 1'b0, 16'h4000 + 16'(c));
      @(negedge clk);
      ce  = 1'b0;
      clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      chk_bit("drop_beats_clr", drop, 1'b1);
      idle(1);
      chk_bit("drop_sticky", drop, 1'b1);
      check("bp_head_stable", {m_tlast, m_tdata}, {1'b0, 64'h1003_1002_1001_1000});

      // Drain the queued words in order
      m_tready = 1'b1;
      wait_words(4, "drain_count");
      chk_word("drain_w0", 0, {1'b0, 64'h1003_1002_1001_1000});
      chk_word("drain_w1", 1, {1'b1, 64'h1007_1006_1005_1004});
      chk_word("drain_w2", 2, {1'b0, 64'h2003_2002_2001_2000});
      chk_word("drain_w3", 3, {1'b1, 64'h2007_2006_2005_2004});
      idle(1);
      chk_bit("drain_empty", m_tvalid, 1'b0);
      q.delete();

      // Asynchronous reset mid-stream with a queued word
      m_tready = 1'b0;
      for (int c = 4; c < NCHAN; c++) drive(1'b1, 1'b0, 16'h4000 + 16'(c));
      idle(3);
      check("pre_rst_word", {m_tlast, m_tdata}, {1'b1, 64'h4007_4006_4005_4004});
      check("pre_rst_spec_count", {33'd0, spec_count}, 65'd6);
      #3 rst = 1'b0;
      #1;
      chk_bit("async_rst_tvalid", m_tvalid, 1'b0);
      check("async_rst_tdata", {1'b0, m_tdata}, 65'd0);
      check("async_rst_spec_count", {33'd0, spec_count}, 65'd0);
      chk_bit("async_rst_drop", drop, 1'b0);
      #8 rst = 1'b1;
      m_tready = 1'b1;
      for (int c = 0; c < NCHAN; c++) drive(1'b1, 1'b0, 16'h5000 + 16'(c));
      idle(5);
      check("post_rst_no_output", 65'(q.size()), 65'd0);
      chk_bit("post_rst_tvalid", m_tvalid, 1'b0);

      // Normal operation resumes after a sync
      ramp_spectrum(0);
      idle(4);
      wait_words(2, "resume_count");
      chk_word("resume_w0", 0, {1'b0, 64'h0003_0002_0001_0000});
      chk_word("resume_w1", 1, {1'b1, 64'h0007_0006_0005_0004});
      check("resume_spec_count", {33'd0, spec_count}, 65'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spec_packer.md
SPEC_PACKER -- requirements
Module: spec_packer

Interface
REQ-001 Parameter: NCHAN, 2048, channels per spectrum; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter: FIFO_DEPTH, 4, output FIFO depth in 64-bit words; SHALL be a power of two and at least 2.
REQ-003 Port: clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-low.
REQ-005 Port: ce  input  1  input sample qualifier; data_in and sync_in SHALL be ignored when ce=0.
REQ-006 Port: sync_in  input  1  with ce=1, marks data_in as channel 0 of a spectrum.
REQ-007 Port: data_in  input  16  requantized sample {re[7:0], im[7:0]} from requant.requant_out.
REQ-008 Port: m_tdata  output  64  packed word; channel 4k in [15:0], 4k+1 in [31:16], 4k+2 in [47:32], 4k+3 in [63:48].
REQ-009 Port: m_tvalid  output  1  m_tdata valid.
REQ-010 Port: m_tready  input  1  downstream accept; a word transfers when m_tvalid=1 and m_tready=1.
REQ-011 Port: m_tlast  output  1  high on the last word of a spectrum (word NCHAN/4-1).
REQ-012 Port: spec_count  output  32  number of complete spectra pushed into the FIFO, wraps modulo 2^32.
REQ-013 Port: drop  output  1  sticky: a completed word was discarded because the FIFO was full.
REQ-014 Port: resync  output  1  sticky: sync_in arrived while a spectrum was in progress.
REQ-015 Port: clr  input  1  synchronous clear of drop and resync.

Function
REQ-016 The block SHALL implement two states: WaitSync and Packing.
REQ-017 In WaitSync, samples without sync_in SHALL be discarded; ce=1 with sync_in=1 SHALL store data_in as channel 0 and enter Packing with channel counter 1.
REQ-018 In Packing, each ce=1 SHALL store data_in into lane (channel mod 4) and increment the channel counter.
REQ-019 When the counter reaches NCHAN it SHALL wrap to 0 and the block SHALL remain in Packing; the next sample is treated as channel 0 with no sync_in required.
REQ-020 On the ce cycle storing lane 3, the assembled word SHALL be pushed into the FIFO in the following cycle, with tlast=1 iff the word holds channel NCHAN-1.
REQ-021 Push latency: a word SHALL be visible on m_tdata/m_tvalid no later than 2 cycles after the ce cycle of its lane-3 sample, when the FIFO is empty.
REQ-022 If the FIFO is full at push time, the word SHALL be discarded, drop SHALL set, and packing SHALL continue; spec_count SHALL NOT increment for a discarded tlast word.
REQ-023 spec_count SHALL increment by 1 when a tlast word is successfully pushed.
REQ-024 sync_in=1 with ce=1 in Packing at a channel other than 0 SHALL discard the partial word, set resync, and restart at channel 0 with the current data_in.
REQ-025 sync_in=1 with ce=1 at expected channel 0 SHALL be accepted silently.
REQ-026 Simultaneous push and pop on a full FIFO SHALL both succeed; no drop is raised.
REQ-027 m_tdata, m_tlast, and m_tvalid SHALL remain stable while m_tvalid=1 and m_tready=0.
REQ-028 clr=1 SHALL clear drop and resync in the next cycle; a concurrent setting event SHALL take priority over clr.

Reset
REQ-029 rst=0 SHALL asynchronously force: state WaitSync; channel counter 0; FIFO empty; m_tvalid=0; m_tlast=0; m_tdata=0; spec_count=0; drop=0; resync=0.
REQ-030 Reset asserted mid-spectrum SHALL discard all partial and queued words; after release, the block SHALL wait for sync_in.
REQ-031 Outputs SHALL be updated only on clk rising edges after rst deassertion.

Verification
REQ-032 Use NCHAN=8 with m_tready=1; sync on sample 0x0000, then ramp 0x0001..0x0007 on consecutive ce -> words 0x0003000200010000 (tlast=0) then 0x0007000600050004 (tlast=1); spec_count=1.
REQ-033 Use NCHAN=8 with m_tready=0 and stream 3 spectra -> exactly FIFO_DEPTH words queued, drop=1, spec_count=2; then raise m_tready -> the 4 queued words drain in order.
REQ-034 Use NCHAN=8 with a second sync_in at channel 5 -> resync=1; the partial word is never emitted; the next word emitted starts with the resync sample in [15:0].
REQ-035 Toggle ce with a 1-in-3 duty cycle over a full spectrum -> output words are identical to the REQ-032 run.
REQ-036 Pull rst low for 1 cycle mid-spectrum, asynchronous to clk -> m_tvalid=0 immediately; samples without sync_in after release produce no output.
REQ-037 Set drop=1, then apply clr=1 -> drop=0 on the next cycle; drive clr=1 on the same cycle as a new drop -> drop stays 1.
